// File: rtl/mem_access_if.sv
// Request/acknowledge data-memory bus between the MEM stage and data memory.
// The MEM stage is the master; the memory (or a model of it) is the slave.
interface mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [1:0]  dmem_sel;
  logic        dmem_ack;
  logic [15:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_sel,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_sel,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access.sv
// MEM stage of the 16-bit pipeline: runs loads/stores on the dmem bus through an
// IDLE/WAIT/DONE machine, stalls the pipeline meanwhile, and feeds MEM/WB.
module mem_access #(
  parameter int                 REG_ADDR_W = 3,
  parameter int                 ALUOP_W    = 8,
  parameter int                 TIMEOUT    = 15,
  parameter logic [ALUOP_W-1:0] OP_LW      = 8'h23,
  parameter logic [ALUOP_W-1:0] OP_LB      = 8'h20,
  parameter logic [ALUOP_W-1:0] OP_LBU     = 8'h24,
  parameter logic [ALUOP_W-1:0] OP_SW      = 8'h2B,
  parameter logic [ALUOP_W-1:0] OP_SB      = 8'h28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            stall,
  input  logic [REG_ADDR_W-1:0] mem_wd,
  input  logic                  mem_wreg,
  input  logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_hi,
  input  logic [15:0]           mem_lo,
  input  logic                  mem_whilo,
  input  logic [ALUOP_W-1:0]    mem_aluop,
  input  logic [15:0]           mem_mem_addr,
  input  logic [15:0]           mem_data_store,
  mem_access_if.master          dmem,
  output logic [REG_ADDR_W-1:0] wb_wd,
  output logic                  wb_wreg,
  output logic [15:0]           wb_wdata,
  output logic [15:0]           wb_hi,
  output logic [15:0]           wb_lo,
  output logic                  wb_whilo,
  output logic                  stallreq_mem,
  output logic                  align_err,
  output logic                  bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [15:0]          rdata_q, rdata_d;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic [15:0]          addr_q, addr_d;
  logic [15:0]          wdata_q, wdata_d;
  logic [1:0]           sel_q, sel_d;
  logic [ALUOP_W-1:0]   op_q, op_d;
  logic                 align_err_q, align_err_d;
  logic                 bus_err_q, bus_err_d;

  logic is_lw, is_lb, is_lbu, is_sw, is_sb;
  logic is_mem_op, is_store, misaligned, aligned_op;
  logic [7:0]  byte_q;
  logic [15:0] store_wdata;
  logic [1:0]  store_sel;
  logic        unused_stall;

  assign unused_stall = ^{stall[5], stall[3:0]};

  assign is_lw      = (mem_aluop == OP_LW);
  assign is_lb      = (mem_aluop == OP_LB);
  assign is_lbu     = (mem_aluop == OP_LBU);
  assign is_sw      = (mem_aluop == OP_SW);
  assign is_sb      = (mem_aluop == OP_SB);
  assign is_store   = is_sw | is_sb;
  assign is_mem_op  = is_lw | is_lb | is_lbu | is_sw | is_sb;
  assign misaligned = (is_lw | is_sw) & mem_mem_addr[0];
  assign aligned_op = is_mem_op & ~misaligned;

  // Byte stores put the byte on both lanes and let the lane enables pick one.
  always_comb begin
    store_wdata = 16'h0000;
    store_sel   = 2'b11;
    if (is_sw) begin
      store_wdata = mem_data_store;
    end else if (is_sb) begin
      store_wdata = {mem_data_store[7:0], mem_data_store[7:0]};
      store_sel   = mem_mem_addr[0] ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    req_d       = 1'b0;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    op_d        = op_q;
    align_err_d = 1'b0;
    bus_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!stall[4]) begin
          if (aligned_op) begin
            state_d = S_WAIT;
            req_d   = 1'b1;
            cnt_d   = 8'd0;
            we_d    = is_store;
            addr_d  = mem_mem_addr;
            wdata_d = store_wdata;
            sel_d   = store_sel;
            op_d    = mem_aluop;
          end else if (misaligned) begin
            align_err_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (dmem.dmem_ack) begin
          rdata_d = dmem.dmem_rdata;
          state_d = S_DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d     = cnt_q + 8'd1;
          rdata_d   = 16'h0000;
          bus_err_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          req_d = 1'b1;
        end
      end
      S_DONE: begin
        if (!stall[4]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      rdata_q     <= 16'h0000;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 16'h0000;
      wdata_q     <= 16'h0000;
      sel_q       <= 2'b00;
      op_q        <= '0;
      align_err_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      op_q        <= op_d;
      align_err_q <= align_err_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign byte_q = addr_q[0] ? rdata_q[15:8] : rdata_q[7:0];

  // In DONE the result comes from the captured op; otherwise memory ops are held back.
  always_comb begin
    wb_wd        = mem_wd;
    wb_wreg      = mem_wreg;
    wb_wdata     = mem_wdata;
    wb_hi        = mem_hi;
    wb_lo        = mem_lo;
    wb_whilo     = mem_whilo;
    stallreq_mem = (state_q == S_WAIT) || ((state_q == S_IDLE) && aligned_op);
    if (state_q == S_DONE) begin
      if (op_q == OP_LW) begin
        wb_wdata = rdata_q;
      end else if (op_q == OP_LB) begin
        wb_wdata = {{8{byte_q[7]}}, byte_q};
      end else if (op_q == OP_LBU) begin
        wb_wdata = {8'h00, byte_q};
      end else begin
        wb_wreg = 1'b0;
      end
    end else if (is_mem_op) begin
      wb_wreg = 1'b0;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_sel   = sel_q;
  assign align_err       = align_err_q;
  assign bus_err         = bus_err_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads, stores, misalignment, timeout,
// reset during a transaction and holding the result in DONE.
module tb_mem_access;
  localparam logic [7:0] OP_LW  = 8'h23;
  localparam logic [7:0] OP_LB  = 8'h20;
  localparam logic [7:0] OP_LBU = 8'h24;
  localparam logic [7:0] OP_SW  = 8'h2B;
  localparam logic [7:0] OP_SB  = 8'h28;
  localparam logic [7:0] OP_NOP = 8'h00;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [2:0]  mem_wd;
  logic        mem_wreg;
  logic [15:0] mem_wdata, mem_hi, mem_lo;
  logic        mem_whilo;
  logic [7:0]  mem_aluop;
  logic [15:0] mem_mem_addr, mem_data_store;
  logic [2:0]  wb_wd;
  logic        wb_wreg;
  logic [15:0] wb_wdata, wb_hi, wb_lo;
  logic        wb_whilo;
  logic        stallreq_mem, align_err, bus_err;

  int errors = 0;
  int checks = 0;
  int req_cycles;

  mem_access_if dmem ();

  mem_access dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .mem_wd         (mem_wd),
    .mem_wreg       (mem_wreg),
    .mem_wdata      (mem_wdata),
    .mem_hi         (mem_hi),
    .mem_lo         (mem_lo),
    .mem_whilo      (mem_whilo),
    .mem_aluop      (mem_aluop),
    .mem_mem_addr   (mem_mem_addr),
    .mem_data_store (mem_data_store),
    .dmem           (dmem.master),
    .wb_wd          (wb_wd),
    .wb_wreg        (wb_wreg),
    .wb_wdata       (wb_wdata),
    .wb_hi          (wb_hi),
    .wb_lo          (wb_lo),
    .wb_whilo       (wb_whilo),
    .stallreq_mem   (stallreq_mem),
    .align_err      (align_err),
    .bus_err        (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] op, input logic [15:0] addr,
                               input logic [15:0] data);
    mem_aluop      = op;
    mem_mem_addr   = addr;
    mem_data_store = data;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Load with the ack returned in the first WAIT cycle.
  task automatic doLoad(input string tag, input logic [7:0] op, input logic [15:0] addr,
                        input logic [15:0] rdata, input logic [15:0] expected);
    applyStimulus(op, addr, 16'h0000);
    checkOutput({tag, " idle stallreq"}, 16'(stallreq_mem), 16'h1);
    tick();
    dmem.dmem_ack   = 1'b1;
    dmem.dmem_rdata = rdata;
    #1;
    checkOutput({tag, " wait req"}, 16'(dmem.dmem_req), 16'h1);
    checkOutput({tag, " wait addr"}, dmem.dmem_addr, addr);
    tick();
    dmem.dmem_ack   = 1'b0;
    dmem.dmem_rdata = 16'h0000;
    #1;
    checkOutput({tag, " done stallreq"}, 16'(stallreq_mem), 16'h0);
    checkOutput({tag, " done wdata"}, wb_wdata, expected);
    checkOutput({tag, " done wreg"}, 16'(wb_wreg), 16'h1);
  endtask

  // LW with no ack for 15 WAIT cycles, optionally acking on the last one.
  task automatic runTimeout(input string tag, input logic ack_last);
    applyStimulus(OP_LW, 16'h0040, 16'h0000);
    req_cycles = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 15 && ack_last) begin
        dmem.dmem_ack   = 1'b1;
        dmem.dmem_rdata = 16'h5A5A;
      end
      #1;
      if (dmem.dmem_req === 1'b1) req_cycles++;
    end
    tick();
    dmem.dmem_ack   = 1'b0;
    dmem.dmem_rdata = 16'h0000;
    #1;
    checkOutput({tag, " req cycles"}, 16'(req_cycles), 16'd15);
    checkOutput({tag, " done req"}, 16'(dmem.dmem_req), 16'h0);
    checkOutput({tag, " bus_err"}, 16'(bus_err), ack_last ? 16'h0 : 16'h1);
    checkOutput({tag, " wdata"}, wb_wdata, ack_last ? 16'h5A5A : 16'h0000);
    tick();
    applyStimulus(OP_NOP, 16'h0000, 16'h0000);
    checkOutput({tag, " bus_err drop"}, 16'(bus_err), 16'h0);
  endtask

  initial begin
    rst             = 1'b0;
    stall           = 6'b000000;
    mem_wd          = 3'd5;
    mem_wreg        = 1'b1;
    mem_wdata       = 16'h1111;
    mem_hi          = 16'hAAAA;
    mem_lo          = 16'h5555;
    mem_whilo       = 1'b1;
    mem_aluop       = OP_NOP;
    mem_mem_addr    = 16'h0000;
    mem_data_store  = 16'h0000;
    dmem.dmem_ack   = 1'b0;
    dmem.dmem_rdata = 16'h0000;

    tick();
    tick();
    checkOutput("reset req", 16'(dmem.dmem_req), 16'h0);
    checkOutput("reset we", 16'(dmem.dmem_we), 16'h0);
    checkOutput("reset addr", dmem.dmem_addr, 16'h0000);
    checkOutput("reset sel", 16'(dmem.dmem_sel), 16'h0);
    checkOutput("reset errs", 16'({align_err, bus_err}), 16'h0);
    checkOutput("reset stallreq", 16'(stallreq_mem), 16'h0);
    checkOutput("pass wdata", wb_wdata, 16'h1111);
    checkOutput("pass hi", wb_hi, 16'hAAAA);
    checkOutput("pass lo", wb_lo, 16'h5555);
    rst = 1'b1;
    tick();

    doLoad("lw", OP_LW, 16'h0010, 16'hBEEF, 16'hBEEF);
    tick();
    applyStimulus(OP_NOP, 16'h0000, 16'h0000);
    checkOutput("lw back idle", 16'(stallreq_mem), 16'h0);
    checkOutput("lw back pass", wb_wdata, 16'h1111);

    doLoad("lb", OP_LB, 16'h0011, 16'h80AA, 16'hFF80);
    tick();
    doLoad("lbu", OP_LBU, 16'h0011, 16'h80AA, 16'h0080);
    tick();

    applyStimulus(OP_SB, 16'h0021, 16'h1234);
    checkOutput("sb stallreq", 16'(stallreq_mem), 16'h1);
    tick();
    dmem.dmem_ack = 1'b1;
    #1;
    checkOutput("sb we", 16'(dmem.dmem_we), 16'h1);
    checkOutput("sb sel", 16'(dmem.dmem_sel), 16'h2);
    checkOutput("sb wdata", dmem.dmem_wdata, 16'h3434);
    tick();
    dmem.dmem_ack = 1'b0;
    #1;
    checkOutput("sb wreg", 16'(wb_wreg), 16'h0);
    tick();

    applyStimulus(OP_SW, 16'h0003, 16'hCAFE);
    checkOutput("sw mis stallreq", 16'(stallreq_mem), 16'h0);
    checkOutput("sw mis wreg", 16'(wb_wreg), 16'h0);
    tick();
    applyStimulus(OP_NOP, 16'h0000, 16'h0000);
    checkOutput("sw mis align_err", 16'(align_err), 16'h1);
    checkOutput("sw mis req", 16'(dmem.dmem_req), 16'h0);
    tick();
    checkOutput("sw mis align drop", 16'(align_err), 16'h0);
    checkOutput("sw mis req later", 16'(dmem.dmem_req), 16'h0);

    runTimeout("timeout", 1'b0);
    runTimeout("ack last", 1'b1);

    applyStimulus(OP_LW, 16'h0050, 16'h0000);
    tick();
    tick();
    checkOutput("rst wait req", 16'(dmem.dmem_req), 16'h1);
    rst = 1'b0;
    tick();
    checkOutput("rst req drop", 16'(dmem.dmem_req), 16'h0);
    rst             = 1'b1;
    dmem.dmem_ack   = 1'b1;
    dmem.dmem_rdata = 16'hDEAD;
    applyStimulus(OP_NOP, 16'h0000, 16'h0000);
    checkOutput("rst idle stallreq", 16'(stallreq_mem), 16'h0);
    tick();
    dmem.dmem_ack = 1'b0;
    #1;
    checkOutput("stray ack req", 16'(dmem.dmem_req), 16'h0);
    checkOutput("stray ack pass", wb_wdata, 16'h1111);
    tick();

    doLoad("hold", OP_LW, 16'h0012, 16'h1357, 16'h1357);
    stall = 6'b010000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("hold wdata", wb_wdata, 16'h1357);
      checkOutput("hold stallreq", 16'(stallreq_mem), 16'h0);
    end
    stall = 6'b000000;
    tick();
    applyStimulus(OP_NOP, 16'h0000, 16'h0000);
    checkOutput("hold release pass", wb_wdata, 16'h1111);
    checkOutput("hold release req", 16'(dmem.dmem_req), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
